// File: rtl/coin_pulse_conditioner.sv
// coin_pulse_conditioner
// Turns raw, asynchronous, bouncy coin-sensor levels into clean one-cycle
// five_rup / ten_rup pulses for the vending FSMs. It also serialises coins that
// arrive close together, rejects coins when vending is disabled or a coin of
// the same value is still waiting, and keeps running accepted/rejected tallies.
// Channel index 0 is the 5-rupee sensor and index 1 is the 10-rupee sensor.

module coin_pulse_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned GAP_CYCLES      = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        coin5_raw,
   input  logic        coin10_raw,
   input  logic        coin_enable,
   output logic        five_rup,
   output logic        ten_rup,
   output logic        coin_reject,
   output logic [15:0] accepted_total,
   output logic [7:0]  rejected_count
);

   localparam int unsigned NCH   = 2;
   localparam int unsigned DBW   = 8;
   localparam int unsigned GW    = 4;
   localparam int unsigned TOTW  = 16;
   localparam int unsigned RCW   = 8;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_GAP  = 1'b1
   } state_t;

   // synchroniser and debounce state
   logic [NCH-1:0] r_sync1;
   logic [NCH-1:0] r_sync2;
   logic [NCH-1:0] r_deb;
   logic [NCH-1:0] r_deb_q;
   logic [DBW-1:0] r_db_cnt [NCH];

   // coin bookkeeping
   logic [NCH-1:0] r_pend;
   state_t         r_state;
   logic [GW-1:0]  r_gap_cnt;

   // registered outputs
   logic           r_five;
   logic           r_ten;
   logic           r_reject;
   logic [TOTW-1:0] r_total;
   logic [RCW-1:0]  r_rej_cnt;

   // combinational helpers
   logic [NCH-1:0] w_rise;
   logic [NCH-1:0] w_issue;
   logic [NCH-1:0] w_pend_kept;
   logic [NCH-1:0] w_acc;
   logic [NCH-1:0] w_rej;
   logic [NCH-1:0] w_pend_nxt;
   logic [1:0]     w_rej_n;
   state_t         w_state_nxt;
   logic [GW-1:0]  w_gap_nxt;
   logic           w_issue5;
   logic           w_issue10;
   logic [RCW:0]   w_rej_sum;

   // two-flop synchroniser per raw sensor input
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= {coin10_raw, coin5_raw};
         r_sync2 <= r_sync1;
      end
   end

   // debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_deb   <= '0;
         r_deb_q <= '0;
         for (int c = 0; c < int'(NCH); c++) begin
            r_db_cnt[c] <= '0;
         end
      end else begin
         r_deb_q <= r_deb;
         for (int c = 0; c < int'(NCH); c++) begin
            if (r_sync2[c] == r_deb[c]) begin
               r_db_cnt[c] <= '0;
            end else if (r_db_cnt[c] == DBW'(DEBOUNCE_CYCLES - 1)) begin
               r_deb[c]    <= r_sync2[c];
               r_db_cnt[c] <= '0;
            end else begin
               r_db_cnt[c] <= r_db_cnt[c] + DBW'(1);
            end
         end
      end
   end

   // a coin is the rising edge of the debounced level; falling edges are ignored
   always_comb begin
      w_rise = r_deb & ~r_deb_q;
   end

   // scheduler state register: IDLE may issue, GAP enforces idle spacing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_gap_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_gap_cnt <= w_gap_nxt;
      end
   end

   // scheduler next state: one pulse per eligible cycle, five wins over ten
   always_comb begin
      w_state_nxt = r_state;
      w_gap_nxt   = r_gap_cnt;
      w_issue5    = 1'b0;
      w_issue10   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_pend[0]) begin
               w_issue5 = 1'b1;
            end else if (r_pend[1]) begin
               w_issue10 = 1'b1;
            end
            if ((r_pend != '0) && (GAP_CYCLES != 0)) begin
               w_state_nxt = S_GAP;
               w_gap_nxt   = GW'(GAP_CYCLES);
            end
         end
         S_GAP: begin
            if (r_gap_cnt <= GW'(1)) begin
               w_state_nxt = S_IDLE;
               w_gap_nxt   = '0;
            end else begin
               w_gap_nxt = r_gap_cnt - GW'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_gap_nxt   = '0;
         end
      endcase
   end

   // accept/reject decision; a flag being issued this cycle can take a new coin
   always_comb begin
      w_issue     = {w_issue10, w_issue5};
      w_pend_kept = r_pend & ~w_issue;
      w_acc       = w_rise & ~w_pend_kept & {NCH{coin_enable}};
      w_rej       = w_rise & ~w_acc;
      w_pend_nxt  = w_pend_kept | w_acc;
      w_rej_n     = 2'({1'b0, w_rej[0]}) + 2'({1'b0, w_rej[1]});
      w_rej_sum   = {1'b0, r_rej_cnt} + (RCW+1)'(w_rej_n);
   end

   // pending flags: one outstanding coin per channel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend <= '0;
      end else begin
         r_pend <= w_pend_nxt;
      end
   end

   // output pulses and running tallies, all updated on the pulse edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_five    <= 1'b0;
         r_ten     <= 1'b0;
         r_reject  <= 1'b0;
         r_total   <= '0;
         r_rej_cnt <= '0;
      end else begin
         r_five   <= w_issue5;
         r_ten    <= w_issue10;
         r_reject <= |w_rej;
         if (w_issue5) begin
            r_total <= r_total + TOTW'(5);
         end else if (w_issue10) begin
            r_total <= r_total + TOTW'(10);
         end
         if (w_rej_sum > (RCW+1)'(255)) begin
            r_rej_cnt <= RCW'(255);
         end else begin
            r_rej_cnt <= w_rej_sum[RCW-1:0];
         end
      end
   end

   assign five_rup       = r_five;
   assign ten_rup        = r_ten;
   assign coin_reject    = r_reject;
   assign accepted_total = r_total;
   assign rejected_count = r_rej_cnt;

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// Bench for coin_pulse_conditioner: two instances share the same sensor inputs
// (gap of 1 and gap of 15 cycles). Each has a reference model and a queue of
// expected output cycles that a separate monitor drains and compares.

module tb_coin_pulse_conditioner;

   localparam int unsigned D = 4;

   logic clk         = 1'b0;
   logic rst         = 1'b1;
   logic coin5_raw   = 1'b0;
   logic coin10_raw  = 1'b0;
   logic coin_enable = 1'b1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          cyc;
      bit          f5;
      bit          f10;
      bit          rj;
      logic [15:0] tot;
      logic [7:0]  rc;
   } rec_t;

   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string name, input string act, input string exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %s, expected %s", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      chk(act == exp, name, $sformatf("%0d", act), $sformatf("%0d", exp));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_sb
      localparam int unsigned GAP = (g == 0) ? 1 : 15;

      logic        w5;
      logic        w10;
      logic        wrej;
      logic [15:0] wtot;
      logic [7:0]  wrc;

      coin_pulse_conditioner #(
         .DEBOUNCE_CYCLES(D),
         .GAP_CYCLES     (GAP)
      ) u_dut (
         .clk           (clk),
         .rst           (rst),
         .coin5_raw     (coin5_raw),
         .coin10_raw    (coin10_raw),
         .coin_enable   (coin_enable),
         .five_rup      (w5),
         .ten_rup       (w10),
         .coin_reject   (wrej),
         .accepted_total(wtot),
         .rejected_count(wrc)
      );

      // reference model state
      int          edge_n  = 0;
      bit [D+1:0]  hist5   = '0;
      bit [D+1:0]  hist10  = '0;
      bit          deb5    = 1'b0;
      bit          deb10   = 1'b0;
      bit          rise5   = 1'b0;
      bit          rise10  = 1'b0;
      bit          pend5   = 1'b0;
      bit          pend10  = 1'b0;
      int          next_ok = 0;
      logic [15:0] m_tot   = '0;
      logic [7:0]  m_rc    = '0;
      bit          iss5;
      bit          iss10;
      int          nrj;
      rec_t        q[$];

      // monitor statistics
      int          n5     = 0;
      int          n10    = 0;
      int          nrejp  = 0;
      int          last5  = 0;
      int          last10 = 0;
      rec_t        mr;

      // model: a level is a coin once D samples (seen two edges late) all disagree
      // with the accepted level; pulses need GAP idle cycles between them
      always @(posedge clk or posedge rst) begin
         if (rst) begin
            hist5   = '0;
            hist10  = '0;
            deb5    = 1'b0;
            deb10   = 1'b0;
            rise5   = 1'b0;
            rise10  = 1'b0;
            pend5   = 1'b0;
            pend10  = 1'b0;
            next_ok = 0;
            m_tot   = '0;
            m_rc    = '0;
            q.delete();
         end else begin
            edge_n++;
            iss5  = 1'b0;
            iss10 = 1'b0;
            nrj   = 0;
            if (edge_n >= next_ok && (pend5 || pend10)) begin
               if (pend5) begin
                  iss5  = 1'b1;
                  pend5 = 1'b0;
                  m_tot = m_tot + 16'd5;
               end else begin
                  iss10  = 1'b1;
                  pend10 = 1'b0;
                  m_tot  = m_tot + 16'd10;
               end
               next_ok = edge_n + int'(GAP) + 1;
            end
            if (rise5) begin
               if (coin_enable && !pend5) pend5 = 1'b1;
               else nrj++;
            end
            if (rise10) begin
               if (coin_enable && !pend10) pend10 = 1'b1;
               else nrj++;
            end
            if (int'(m_rc) + nrj > 255) m_rc = 8'd255;
            else m_rc = 8'(int'(m_rc) + nrj);
            if (iss5 || iss10 || nrj != 0)
               q.push_back('{edge_n, iss5, iss10, (nrj != 0), m_tot, m_rc});
            hist5  = {hist5[D:0], coin5_raw};
            hist10 = {hist10[D:0], coin10_raw};
            rise5  = 1'b0;
            rise10 = 1'b0;
            if (hist5[D+1:2] == {D{~deb5}}) begin
               deb5  = ~deb5;
               rise5 = deb5;
            end
            if (hist10[D+1:2] == {D{~deb10}}) begin
               deb10  = ~deb10;
               rise10 = deb10;
            end
         end
      end

      // monitor: every DUT output cycle must match the next expected record
      always @(negedge clk) begin
         if (!rst) begin
            if (w5) begin
               n5++;
               last5 = edge_n;
            end
            if (w10) begin
               n10++;
               last10 = edge_n;
            end
            if (wrej) nrejp++;
            if (w5 || w10 || wrej) begin
               if (q.size() == 0) begin
                  chk(1'b0, $sformatf("g%0d_unexpected_output", g),
                      $sformatf("cyc=%0d f5=%0b f10=%0b rej=%0b", edge_n, w5, w10, wrej),
                      "no output");
               end else begin
                  mr = q.pop_front();
                  chk(mr.cyc == edge_n && mr.f5 == w5 && mr.f10 == w10 && mr.rj == wrej &&
                      mr.tot == wtot && mr.rc == wrc,
                      $sformatf("g%0d_output", g),
                      $sformatf("cyc=%0d f5=%0b f10=%0b rej=%0b tot=%0d rc=%0d",
                                edge_n, w5, w10, wrej, wtot, wrc),
                      $sformatf("cyc=%0d f5=%0b f10=%0b rej=%0b tot=%0d rc=%0d",
                                mr.cyc, mr.f5, mr.f10, mr.rj, mr.tot, mr.rc));
               end
            end else if (q.size() != 0 && q[0].cyc <= edge_n) begin
               mr = q.pop_front();
               chk(1'b0, $sformatf("g%0d_missing_output", g),
                   $sformatf("nothing at cyc=%0d", edge_n),
                   $sformatf("cyc=%0d f5=%0b f10=%0b rej=%0b", mr.cyc, mr.f5, mr.f10, mr.rj));
            end
         end
      end
   end

   int e0;
   int b5_0, b10_0, br_0, b5_1, b10_1, br_1;

   task automatic snap();
      b5_0  = g_sb[0].n5;
      b10_0 = g_sb[0].n10;
      br_0  = g_sb[0].nrejp;
      b5_1  = g_sb[1].n5;
      b10_1 = g_sb[1].n10;
      br_1  = g_sb[1].nrejp;
   endtask

   initial begin
      rst = 1'b1;
      idle(3);
      chk_int("reset_outputs_g0",
              int'({g_sb[0].w5, g_sb[0].w10, g_sb[0].wrej, g_sb[0].wtot, g_sb[0].wrc}), 0);
      chk_int("reset_outputs_g1",
              int'({g_sb[1].w5, g_sb[1].w10, g_sb[1].wrej, g_sb[1].wtot, g_sb[1].wrc}), 0);
      rst = 1'b0;
      idle(3);

      // single 5-rupee coin held 20 cycles
      snap();
      coin5_raw = 1'b1;
      e0 = g_sb[0].edge_n + 1;
      idle(20);
      coin5_raw = 1'b0;
      idle(20);
      chk_int("s1_five_count", g_sb[0].n5 - b5_0, 1);
      chk_int("s1_latency", g_sb[0].last5 - e0, int'(D) + 3);
      chk_int("s1_total", int'(g_sb[0].wtot), 5);

      // bouncing 10-rupee sensor then stable high
      snap();
      coin10_raw = 1'b1; idle(1);
      coin10_raw = 1'b0; idle(1);
      coin10_raw = 1'b1; idle(1);
      coin10_raw = 1'b0; idle(1);
      coin10_raw = 1'b1;
      e0 = g_sb[0].edge_n + 1;
      idle(10);
      coin10_raw = 1'b0;
      idle(20);
      chk_int("s2_ten_count", g_sb[0].n10 - b10_0, 1);
      chk_int("s2_latency", g_sb[0].last10 - e0, int'(D) + 3);
      chk_int("s2_total", int'(g_sb[0].wtot), 15);

      // both coins together: five first, ten after the gap
      snap();
      coin5_raw  = 1'b1;
      coin10_raw = 1'b1;
      idle(10);
      coin5_raw  = 1'b0;
      coin10_raw = 1'b0;
      idle(30);
      chk_int("s3_pulse_counts_g0", (g_sb[0].n5 - b5_0) * 10 + (g_sb[0].n10 - b10_0), 11);
      chk_int("s3_spacing_g0", g_sb[0].last10 - g_sb[0].last5, 2);
      chk_int("s3_spacing_g1", g_sb[1].last10 - g_sb[1].last5, 16);
      chk_int("s3_total", int'(g_sb[0].wtot), 30);

      // vending disabled: coin rejected
      snap();
      coin_enable = 1'b0;
      idle(2);
      coin10_raw = 1'b1;
      idle(10);
      coin10_raw = 1'b0;
      idle(15);
      coin_enable = 1'b1;
      chk_int("s4_no_ten", g_sb[0].n10 - b10_0, 0);
      chk_int("s4_reject_pulses", g_sb[0].nrejp - br_0, 1);
      chk_int("s4_rejected_count", int'(g_sb[0].wrc), 1);
      chk_int("s4_total_unchanged", int'(g_sb[0].wtot), 30);

      // second five arrives while the first still waits behind a long gap
      snap();
      coin10_raw = 1'b1;
      idle(2);
      coin5_raw = 1'b1;
      idle(5);
      coin5_raw  = 1'b0;
      coin10_raw = 1'b0;
      idle(5);
      coin5_raw = 1'b1;
      idle(5);
      coin5_raw = 1'b0;
      idle(40);
      chk_int("s5_g1_five_count", g_sb[1].n5 - b5_1, 1);
      chk_int("s5_g1_reject_pulses", g_sb[1].nrejp - br_1, 1);
      chk_int("s5_g1_rejected_count", int'(g_sb[1].wrc), 2);
      chk_int("s5_g0_five_count", g_sb[0].n5 - b5_0, 2);

      // reset while a coin is pending
      coin5_raw = 1'b1;
      repeat (int'(D) + 3) @(posedge clk);
      @(negedge clk);
      rst       = 1'b1;
      coin5_raw = 1'b0;
      idle(1);
      rst = 1'b0;
      snap();
      idle(20);
      chk_int("s6_no_five_g0", g_sb[0].n5 - b5_0, 0);
      chk_int("s6_no_five_g1", g_sb[1].n5 - b5_1, 0);
      chk_int("s6_total", int'(g_sb[0].wtot), 0);
      chk_int("s6_rejected", int'(g_sb[0].wrc) + int'(g_sb[1].wrc), 0);

      // random sensor activity and enable toggling
      repeat (400) begin
         coin5_raw  = 1'($urandom_range(0, 1));
         coin10_raw = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) coin_enable = ~coin_enable;
         idle(int'($urandom_range(1, 9)));
      end
      coin5_raw   = 1'b0;
      coin10_raw  = 1'b0;
      coin_enable = 1'b1;
      idle(40);
      chk_int("rand_total_g0", int'(g_sb[0].wtot), int'(g_sb[0].m_tot));
      chk_int("rand_total_g1", int'(g_sb[1].wtot), int'(g_sb[1].m_tot));
      chk_int("rand_rejected_g1", int'(g_sb[1].wrc), int'(g_sb[1].m_rc));

      // wrap accepted_total: 4369 x (5+10) + 5 = 65540; long gap saturates rejects
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(2);
      repeat (4369) begin
         coin5_raw  = 1'b1;
         coin10_raw = 1'b1;
         idle(5);
         coin5_raw  = 1'b0;
         coin10_raw = 1'b0;
         idle(5);
      end
      coin5_raw = 1'b1;
      idle(5);
      coin5_raw = 1'b0;
      idle(40);
      chk_int("wrap_total", int'(g_sb[0].wtot), 16'h0004);
      chk_int("wrap_no_rejects_g0", int'(g_sb[0].wrc), 0);
      chk_int("saturate_rejected_g1", int'(g_sb[1].wrc), 255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/coin_pulse_conditioner.md
Name: coin_pulse_conditioner

Overview:
Front-end stage that feeds the per-item vending FSMs and item selector. Converts raw, asynchronous, bouncy coin-sensor levels into clean single-cycle five_rup/ten_rup pulses. Also serialises near-simultaneous coins, rejects coins when vending is disabled or the buffer is full, and keeps running accepted/rejected tallies.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a raw level must hold before it is accepted (legal range 2..255)
GAP_CYCLES, 1, forced idle cycles after every output pulse before the next pulse may issue (legal range 0..15)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
coin5_raw  input  1  raw 5-rupee sensor level, asynchronous, high while coin present
coin10_raw  input  1  raw 10-rupee sensor level, asynchronous, high while coin present
coin_enable  input  1  synchronous; 1 = accept coins, 0 = reject new coins
five_rup  output  1  one-cycle pulse, one accepted 5-rupee coin
ten_rup  output  1  one-cycle pulse, one accepted 10-rupee coin
coin_reject  output  1  one-cycle pulse, one or two coins rejected this cycle
accepted_total  output  16  running sum of rupees issued on five_rup/ten_rup
rejected_count  output  8  number of coins rejected

Behaviour:
- Reset (async assert): all outputs 0; synchronisers, debounced levels, debounce counters, pending flags and gap counter all cleared.
  - Reset mid-operation discards any pending or in-flight coin; no pulse is issued for it after release.
- Synchronisation: 2-FF synchroniser per raw input. No logic is driven from unsynchronised signals.
- Debounce, per channel:
  - Counter increments each cycle the synchronised level differs from the debounced level.
  - Counter clears whenever the two are equal.
  - The debounced level flips when the counter reaches DEBOUNCE_CYCLES; the counter then clears.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Coin event: a rising edge of the debounced level only. Falling edges are ignored. A level held high indefinitely is exactly one coin.
- Coin-event accept/reject:
  - coin_enable=1 and the channel's pending flag is clear: set the pending flag.
  - coin_enable=0, or the pending flag is already set: reject the coin.
  - Rejection: coin_reject=1 next cycle; rejected_count += number rejected that cycle (1 or 2).
  - rejected_count saturates at 255.
- Output scheduler (states IDLE, GAP):
  - IDLE with any pending flag set: issue exactly one pulse, then go to GAP for GAP_CYCLES cycles (stay in IDLE if GAP_CYCLES=0).
  - Priority when both channels are pending: five first, ten at the next eligible cycle.
  - five_rup and ten_rup are never high in the same cycle.
  - The pending flag clears in the same cycle its pulse is issued. A new event on that channel in that same cycle is accepted (the flag stays set).
  - Flags set before coin_enable falls are still delivered.
- accepted_total: += 5 on five_rup, += 10 on ten_rup, updated in the same cycle as the pulse is high; wraps modulo 2^16.
- Latency: from the first clk edge at which coin5_raw/coin10_raw is sampled high (stable), to five_rup/ten_rup high, with the scheduler idle and coin_enable=1: exactly DEBOUNCE_CYCLES+3 cycles. Pulse width is always exactly 1 cycle.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset release, coin5_raw high for 20 cycles with DEBOUNCE_CYCLES=4: five_rup is a single 1-cycle pulse 7 cycles after the first sampling edge; accepted_total=5; no further pulses.
- coin10_raw bounces 1,0,1,0 at 1-cycle intervals, then holds high 10 cycles: exactly one ten_rup pulse, timed from the start of the stable high; accepted_total=10.
- coin5_raw and coin10_raw rise together, GAP_CYCLES=1: five_rup at cycle T, ten_rup at T+2, never overlapping; accepted_total=15.
- coin_enable=0, one 10-rupee coin: no ten_rup; one coin_reject pulse; rejected_count=1; accepted_total unchanged.
- Two 5-rupee coins arrive while an earlier 5 is still pending (GAP_CYCLES=15):
  - Pending coin delivered once.
  - Second arrival rejected: coin_reject=1, rejected_count +1.
- Coin pending, rst pulsed for 1 cycle before its pulse issues: no five_rup after release; accepted_total=0, rejected_count=0.
- Separately: 13108 five-rupee coins wrap accepted_total to 0004 hex.
